// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide unit: op codes, FSM state type,
// counter width and op classification helpers.
package md_pkg;

  // Latency counter width; holds LAT-1 for latencies up to 63.
  localparam int CNT_W = 6;

  // Operation codes carried on the op port.
  localparam logic [3:0] OP_NOP   = 4'd0;
  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MADD  = 4'd5;
  localparam logic [3:0] OP_MADDU = 4'd6;
  localparam logic [3:0] OP_MSUB  = 4'd7;
  localparam logic [3:0] OP_MSUBU = 4'd8;
  localparam logic [3:0] OP_MTHI  = 4'd9;
  localparam logic [3:0] OP_MTLO  = 4'd10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } md_state;

  // Multiply-class ops: plain multiply and the accumulate/subtract variants.
  function automatic logic is_mul(input logic [3:0] op);
    logic r;
    case (op)
      OP_MULT, OP_MULTU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  // Divide-class ops.
  function automatic logic is_div(input logic [3:0] op);
    logic r;
    case (op)
      OP_DIV, OP_DIVU: r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  // Ops whose operands are interpreted as two's complement.
  function automatic logic is_signed_op(input logic [3:0] op);
    logic r;
    case (op)
      OP_MULT, OP_MADD, OP_MSUB, OP_DIV: r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/md_unit_if.sv
// Issue/result bundle between the pipeline and the multiply/divide unit.
interface md_unit_if #(
  parameter int WIDTH = 32
);

  logic             start;
  logic [3:0]       op;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             flush;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  // Pipeline side: issues operations, observes HI/LO and status.
  modport master (
    output start, op, src_a, src_b, flush,
    input  busy, done, hi, lo
  );

  // Unit side.
  modport slave (
    input  start, op, src_a, src_b, flush,
    output busy, done, hi, lo
  );

endinterface

// File: rtl/md_divider.sv
// Combinational signed/unsigned divider. Signed results truncate toward zero
// and the remainder follows the dividend's sign. A zero divisor is flagged
// so the caller can leave HI/LO alone; the internal divisor is forced to 1
// in that case to keep the datapath free of undefined values.
module md_divider #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  input  logic             i_signed,
  output logic [WIDTH-1:0] o_quot,
  output logic [WIDTH-1:0] o_rem,
  output logic             o_div_zero
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic             w_neg_a;
  logic             w_neg_b;
  logic [WIDTH-1:0] w_mag_a;
  logic [WIDTH-1:0] w_mag_b;
  logic [WIDTH-1:0] w_safe_b;
  logic [WIDTH-1:0] w_uquot;
  logic [WIDTH-1:0] w_urem;

  // Reduce to an unsigned divide on magnitudes. The most negative dividend
  // has magnitude 2^(WIDTH-1), which is still representable unsigned, so
  // MIN / -1 yields 2^(WIDTH-1) and re-encodes as MIN with remainder 0.
  always_comb begin
    w_neg_a    = i_signed & i_dividend[WIDTH-1];
    w_neg_b    = i_signed & i_divisor[WIDTH-1];
    w_mag_a    = w_neg_a ? (~i_dividend + ONE) : i_dividend;
    w_mag_b    = w_neg_b ? (~i_divisor + ONE) : i_divisor;
    o_div_zero = (i_divisor == '0);
    w_safe_b   = o_div_zero ? ONE : w_mag_b;
    w_uquot    = w_mag_a / w_safe_b;
    w_urem     = w_mag_a % w_safe_b;
    o_quot     = (w_neg_a ^ w_neg_b) ? (~w_uquot + ONE) : w_uquot;
    o_rem      = w_neg_a ? (~w_urem + ONE) : w_urem;
  end

endmodule

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit owning the HI/LO register pair.
// A start in IDLE latches operands and counts down a fixed latency; the
// result is written to HI/LO on the final busy edge together with a
// one-cycle done pulse. MTHI/MTLO complete immediately from IDLE.
module md_unit
  import md_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10
) (
  input  logic     clk,
  input  logic     reset,
  md_unit_if.slave bus
);

  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  md_state            r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [3:0]         r_op;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_done;

  logic               w_mul_signed;
  logic [2*WIDTH-1:0] w_a_ext;
  logic [2*WIDTH-1:0] w_b_ext;
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_acc;
  logic [WIDTH-1:0]   w_quot;
  logic [WIDTH-1:0]   w_rem;
  logic               w_div_zero;
  logic [2*WIDTH-1:0] w_result;
  logic               w_write;

  // Multiply on operands extended to 2*WIDTH: the truncated product of the
  // sign- or zero-extended values is the exact signed or unsigned product.
  always_comb begin
    w_mul_signed = is_signed_op(r_op);
    w_a_ext      = w_mul_signed ? {{WIDTH{r_a[WIDTH-1]}}, r_a} : {{WIDTH{1'b0}}, r_a};
    w_b_ext      = w_mul_signed ? {{WIDTH{r_b[WIDTH-1]}}, r_b} : {{WIDTH{1'b0}}, r_b};
    w_prod       = w_a_ext * w_b_ext;
    w_acc        = {r_hi, r_lo};
  end

  md_divider #(
    .WIDTH (WIDTH)
  ) u_div (
    .i_dividend (r_a),
    .i_divisor  (r_b),
    .i_signed   (w_mul_signed),
    .o_quot     (w_quot),
    .o_rem      (w_rem),
    .o_div_zero (w_div_zero)
  );

  // Select the HI/LO value for the completion edge; divide by zero keeps
  // the current contents while still completing normally.
  always_comb begin
    w_result = w_acc;
    w_write  = 1'b1;
    case (r_op)
      OP_MULT, OP_MULTU: w_result = w_prod;
      OP_MADD, OP_MADDU: w_result = w_acc + w_prod;
      OP_MSUB, OP_MSUBU: w_result = w_acc - w_prod;
      OP_DIV, OP_DIVU: begin
        w_result = {w_rem, w_quot};
        w_write  = ~w_div_zero;
      end
      default: w_write = 1'b0;
    endcase
  end

  // Control FSM, latency counter and HI/LO ownership. Reset beats flush,
  // and flush beats both completion and a new start.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_op    <= OP_NOP;
      r_a     <= '0;
      r_b     <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (bus.flush) begin
        r_state <= ST_IDLE;
        r_cnt   <= '0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (bus.start) begin
              if (is_mul(bus.op) || is_div(bus.op)) begin
                r_op    <= bus.op;
                r_a     <= bus.src_a;
                r_b     <= bus.src_b;
                r_cnt   <= is_div(bus.op) ? DIV_LOAD : MULT_LOAD;
                r_state <= ST_BUSY;
              end else if (bus.op == OP_MTHI) begin
                r_hi <= bus.src_a;
              end else if (bus.op == OP_MTLO) begin
                r_lo <= bus.src_a;
              end
            end
          end
          ST_BUSY: begin
            if (r_cnt == '0) begin
              if (w_write) begin
                r_hi <= w_result[2*WIDTH-1:WIDTH];
                r_lo <= w_result[WIDTH-1:0];
              end
              r_done  <= 1'b1;
              r_state <= ST_IDLE;
            end else begin
              r_cnt <= r_cnt - CNT_ONE;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.busy = (r_state == ST_BUSY);
  assign bus.done = r_done;
  assign bus.hi   = r_hi;
  assign bus.lo   = r_lo;

endmodule

// File: doc/md_unit.md
MD_UNIT -- requirements
Module: md_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand width and width of each of HI and LO.
REQ-002 SHALL have parameter MULT_LAT, default 5: busy cycles for multiply-class ops; legal range 1..63.
REQ-003 SHALL have parameter DIV_LAT, default 10: busy cycles for divide-class ops; legal range 1..63.
REQ-004 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-low reset; 0 = reset.
REQ-006 SHALL have port start  input  1  issue strobe, qualified by op.
REQ-007 SHALL have port op  input  4  operation code from md_pkg.
REQ-008 SHALL have port src_a  input  WIDTH  operand A (rs), already forwarded.
REQ-009 SHALL have port src_b  input  WIDTH  operand B (rt), already forwarded.
REQ-010 SHALL have port flush  input  1  cancel the in-flight operation.
REQ-011 SHALL have port busy  output  1  multi-cycle operation in progress.
REQ-012 SHALL have port done  output  1  one-cycle pulse when HI/LO take a computed result.
REQ-013 SHALL have port hi  output  WIDTH  architectural HI register.
REQ-014 SHALL have port lo  output  WIDTH  architectural LO register.

Function
REQ-015 SHALL support ops MULT, MULTU, DIV, DIVU, MADD, MADDU, MSUB, MSUBU, MTHI and MTLO; every other op code SHALL be a no-op.
REQ-016 SHALL implement a two-state FSM, IDLE and BUSY; busy = (state == BUSY).
REQ-017 In IDLE, start with a multiply/divide-class op SHALL latch src_a, src_b and op, load the counter with LAT-1 and enter BUSY; LAT is MULT_LAT for MULT/MADD/MSUB variants and DIV_LAT for DIV/DIVU.
REQ-018 In BUSY, the counter SHALL decrement on each edge; on the edge where it equals 0, the FSM SHALL write HI/LO, return to IDLE and set done for exactly one cycle.
REQ-019 busy SHALL therefore be high for exactly LAT cycles, starting the cycle after the start edge; HI/LO SHALL remain unchanged while busy is high.
REQ-020 MTHI/MTLO with start in IDLE SHALL write hi/lo from src_a at that edge, SHALL NOT assert busy and SHALL NOT pulse done.
REQ-021 start while busy SHALL be ignored (the hazard unit stalls the issuer).
REQ-022 MULT/MULTU SHALL set {hi,lo} to the signed/unsigned 2*WIDTH-bit product.
REQ-023 MADD(U)/MSUB(U) SHALL set {hi,lo} to {hi,lo} +/- product, modulo 2^(2*WIDTH), using {hi,lo} as sampled at the completion edge.
REQ-024 DIV/DIVU SHALL set lo to the quotient and hi to the remainder; signed division SHALL truncate toward zero, with the remainder taking the sign of the dividend.
REQ-025 Divide by zero SHALL still take DIV_LAT cycles and pulse done, and SHALL leave hi/lo unchanged.
REQ-026 Signed DIV of the most negative value by -1 SHALL give lo = the most negative value and hi = 0.
REQ-027 flush in BUSY SHALL return the FSM to IDLE at that edge, leave hi/lo unchanged and suppress done.
REQ-028 flush on the completion edge SHALL win: no write and no done.
REQ-029 flush and start on the same edge SHALL perform flush only; the start SHALL be dropped, including MTHI/MTLO.

Reset
REQ-030 reset = 0 at a rising edge SHALL set state to IDLE, counter to 0, hi and lo to 0, and done to 0.
REQ-031 Reset asserted mid-operation SHALL abandon the operation with no done pulse; reset SHALL override flush and start.

Structure
REQ-032 Package md_pkg SHALL hold the op code constants, the md_state type and the is_mul/is_div classification functions.
REQ-033 Divide arithmetic SHALL sit in one combinational sub-module, md_divider (signed/unsigned, zero and overflow cases); the multiply SHALL stay inline.
REQ-034 The counter width SHALL be 6 bits, sized for the maximum latency of 63.

Verification
REQ-035 MULT with src_a = 0xFFFFFFFE, src_b = 3 -> busy high 5 cycles, then hi = 0xFFFFFFFF, lo = 0xFFFFFFFA, done high 1 cycle.
REQ-036 DIVU 100/7, then DIV -7/2 -> first hi = 2, lo = 14; second hi = 0xFFFFFFFF, lo = 0xFFFFFFFD; busy high 10 cycles each.
REQ-037 MTLO 5, MTHI 1, then MADDU 0xFFFFFFFF × 2 -> hi = 3, lo = 3 after 5 busy cycles.
REQ-038 DIV by 0 with hi = 0x11, lo = 0x22 -> after 10 cycles done = 1, hi and lo unchanged.
REQ-039 MULT then flush on busy cycle 3 -> busy drops next cycle, no done, hi/lo unchanged; an immediate following MULT completes normally.
REQ-040 reset = 0 during busy cycle 2 of DIV -> busy = 0, hi = lo = 0, no done; a second run with MULT_LAT = 1, DIV_LAT = 1 shows a single busy cycle per op.
